// File: rtl/dac_sample_scheduler.sv
// Paced DAC sample scheduler: PLB IPIF register slice, sample FIFO and
// release of one 10-bit sample per programmable period with a data clock.
module dac_sample_scheduler #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic        Bus2IP_Clk,
  input  logic        Bus2IP_Resetn,
  input  logic [0:31] Bus2IP_Data,
  input  logic [0:2]  Bus2IP_WrCE,
  input  logic [0:2]  Bus2IP_RdCE,
  output logic [0:31] IP2Bus_Data,
  output logic        IP2Bus_WrAck,
  output logic        IP2Bus_RdAck,
  output logic [0:9]  IP2DAC_Data,
  output logic        IP2DAC_DCLKIO,
  output logic        IP2DAC_PWRDN,
  output logic        Underrun_Irq
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_OFF, S_WAIT, S_RUN} state_t;
  state_t state, state_n;

  // Little-endian views of the bus vectors: wdata[0] is bus bit 31.
  logic [31:0]          wdata;
  logic                 unused_wdata;
  logic [0:2]           wr_ce_q, rd_ce_q, wr_rise, rd_rise;
  logic                 wr_one, rd_one;
  logic                 wr_ctrl, wr_sample, wr_div, rd_ctrl, rd_status, rd_div;
  logic                 en, pwrdn, hold, irq_en, ovf, udr;
  logic [DIV_WIDTH-1:0] div, c;
  logic [9:0]           dac_data;
  logic [9:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 empty, full, flush, tick, pop, push_ok, ovf_set, udr_set;
  logic [31:0]          ctrl_word, status_word, div_word, rd_word;

  assign wdata        = Bus2IP_Data;
  assign unused_wdata = ^wdata;

  assign wr_rise   = Bus2IP_WrCE & ~wr_ce_q;
  assign rd_rise   = Bus2IP_RdCE & ~rd_ce_q;
  assign wr_one    = $onehot(wr_rise);
  assign rd_one    = $onehot(rd_rise);
  assign wr_ctrl   = wr_one & wr_rise[0];
  assign wr_sample = wr_one & wr_rise[1];
  assign wr_div    = wr_one & wr_rise[2];
  assign rd_ctrl   = rd_one & rd_rise[0];
  assign rd_status = rd_one & rd_rise[1];
  assign rd_div    = rd_one & rd_rise[2];

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign flush   = wr_ctrl & wdata[2];
  // c >= div rather than == so a shrinking DIV cannot strand the counter
  assign tick    = (state == S_RUN) && (c >= div);
  assign pop     = tick & ~empty & ~flush;
  assign udr_set = tick & empty & ~flush;
  assign push_ok = wr_sample & (~full | pop);
  assign ovf_set = wr_sample & full & ~pop;

  assign ctrl_word   = {27'b0, irq_en, hold, 1'b0, pwrdn, en};
  assign status_word = {16'b0, 8'(count), 4'b0, ovf, udr, full, empty};
  assign div_word    = 32'(div);

  always_comb begin
    rd_word = '0;
    if (rd_ctrl)   rd_word = ctrl_word;
    if (rd_status) rd_word = status_word;
    if (rd_div)    rd_word = div_word;
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      wr_ce_q      <= '0;
      rd_ce_q      <= '0;
      IP2Bus_WrAck <= 1'b0;
      IP2Bus_RdAck <= 1'b0;
      IP2Bus_Data  <= '0;
      en           <= 1'b0;
      pwrdn        <= 1'b1;
      hold         <= 1'b0;
      irq_en       <= 1'b0;
      div          <= DIV_WIDTH'(1);
      ovf          <= 1'b0;
      udr          <= 1'b0;
    end else begin
      wr_ce_q      <= Bus2IP_WrCE;
      rd_ce_q      <= Bus2IP_RdCE;
      IP2Bus_WrAck <= |wr_rise;
      IP2Bus_RdAck <= |rd_rise;
      IP2Bus_Data  <= rd_word;
      if (wr_ctrl) begin
        en     <= wdata[0];
        pwrdn  <= wdata[1];
        hold   <= wdata[3];
        irq_en <= wdata[4];
      end
      if (wr_div) begin
        if (wdata[DIV_WIDTH-1:0] == '0) div <= DIV_WIDTH'(1);
        else                            div <= wdata[DIV_WIDTH-1:0];
      end
      ovf <= ovf_set | (ovf & ~rd_status);
      udr <= udr_set | (udr & ~rd_status);
    end
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata[9:0];
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) state <= S_OFF;
    else                state <= state_n;
  end

  // OFF and WAIT both jump straight to RUN once a sample is queued.
  always_comb begin
    state_n = state;
    if (!en || pwrdn)        state_n = S_OFF;
    else if (flush)          state_n = S_WAIT;
    else if (state != S_RUN) state_n = empty ? S_WAIT : S_RUN;
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      c        <= DIV_WIDTH'(1);
      dac_data <= '0;
    end else begin
      if (state == S_RUN && state_n == S_RUN) c <= tick ? '0 : c + DIV_WIDTH'(1);
      else                                    c <= div;
      if (pop)                  dac_data <= mem[rd_ptr];
      else if (udr_set && !hold) dac_data <= 10'h200;
    end
  end

  assign IP2DAC_Data   = dac_data;
  assign IP2DAC_DCLKIO = (state == S_RUN) && (c > (div >> 1));
  assign IP2DAC_PWRDN  = pwrdn;
  assign Underrun_Irq  = udr & irq_en;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler: register vector table plus
// hand-timed sequences for pacing, underrun, overflow, flush and reset.
module tb_dac_sample_scheduler;
  localparam int unsigned DEPTH = 16;
  localparam logic [0:2] CE_CTRL = 3'b100;
  localparam logic [0:2] CE_SAMP = 3'b010;
  localparam logic [0:2] CE_STAT = 3'b010;
  localparam logic [0:2] CE_DIV  = 3'b001;
  localparam int unsigned NV = 19;

  logic        clk = 1'b0;
  logic        resetn;
  logic [0:31] bus_data;
  logic [0:2]  wr_ce, rd_ce;
  logic [0:31] rd_data;
  logic        wr_ack, rd_ack;
  logic [0:9]  dac_data;
  logic        dclk, pwrdn, irq;
  int unsigned total = 0;
  int unsigned bad = 0;

  typedef struct {
    logic        is_wr;
    logic [0:2]  ce;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  dac_sample_scheduler #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut (
    .Bus2IP_Clk    (clk),
    .Bus2IP_Resetn (resetn),
    .Bus2IP_Data   (bus_data),
    .Bus2IP_WrCE   (wr_ce),
    .Bus2IP_RdCE   (rd_ce),
    .IP2Bus_Data   (rd_data),
    .IP2Bus_WrAck  (wr_ack),
    .IP2Bus_RdAck  (rd_ack),
    .IP2DAC_Data   (dac_data),
    .IP2DAC_DCLKIO (dclk),
    .IP2DAC_PWRDN  (pwrdn),
    .Underrun_Irq  (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Returns at the falling edge inside the ack cycle.
  task automatic bus_wr(input string name, input logic [0:2] ce, input logic [31:0] d);
    @(negedge clk);
    bus_data = d;
    wr_ce    = ce;
    @(negedge clk);
    check({name, "_wrack"}, 32'(wr_ack), 32'h1);
    wr_ce = '0;
  endtask

  task automatic bus_rd(input string name, input logic [0:2] ce, input logic [31:0] exp);
    @(negedge clk);
    rd_ce = ce;
    @(negedge clk);
    check({name, "_rdack"}, 32'(rd_ack), 32'h1);
    check(name, rd_data, exp);
    rd_ce = '0;
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int unsigned acks;
    logic [31:0] exp_d, exp_c;

    vecs[0]  = '{1'b0, CE_CTRL, 32'h0,         32'h0000_0002};
    vecs[1]  = '{1'b0, CE_DIV,  32'h0,         32'h0000_0001};
    vecs[2]  = '{1'b0, CE_STAT, 32'h0,         32'h0000_0001};
    vecs[3]  = '{1'b1, CE_DIV,  32'h0,         32'h0};
    vecs[4]  = '{1'b0, CE_DIV,  32'h0,         32'h0000_0001};
    vecs[5]  = '{1'b1, CE_DIV,  32'h5,         32'h0};
    vecs[6]  = '{1'b0, CE_DIV,  32'h0,         32'h0000_0005};
    vecs[7]  = '{1'b1, CE_DIV,  32'hABCD_1234, 32'h0};
    vecs[8]  = '{1'b0, CE_DIV,  32'h0,         32'h0000_1234};
    vecs[9]  = '{1'b1, CE_CTRL, 32'h1A,        32'h0};
    vecs[10] = '{1'b0, CE_CTRL, 32'h0,         32'h0000_001A};
    vecs[11] = '{1'b1, CE_CTRL, 32'h06,        32'h0};
    vecs[12] = '{1'b0, CE_CTRL, 32'h0,         32'h0000_0002};
    vecs[13] = '{1'b1, 3'b101,  32'h9,         32'h0};
    vecs[14] = '{1'b0, CE_CTRL, 32'h0,         32'h0000_0002};
    vecs[15] = '{1'b0, CE_DIV,  32'h0,         32'h0000_1234};
    vecs[16] = '{1'b0, 3'b110,  32'h0,         32'h0};
    vecs[17] = '{1'b1, CE_DIV,  32'h1,         32'h0};
    vecs[18] = '{1'b0, CE_DIV,  32'h0,         32'h0000_0001};

    resetn   = 1'b0;
    bus_data = '0;
    wr_ce    = '0;
    rd_ce    = '0;
    step(3);
    check("rst_dac_data", 32'(dac_data), 32'h0);
    check("rst_dclk",     32'(dclk),     32'h0);
    check("rst_pwrdn",    32'(pwrdn),    32'h1);
    check("rst_irq",      32'(irq),      32'h0);
    check("rst_wrack",    32'(wr_ack),   32'h0);
    check("rst_rdack",    32'(rd_ack),   32'h0);
    check("rst_rd_data",  rd_data,       32'h0);
    resetn = 1'b1;

    for (int i = 0; i < int'(NV); i++) begin
      if (vecs[i].is_wr) bus_wr($sformatf("vec%0d", i), vecs[i].ce, vecs[i].data);
      else               bus_rd($sformatf("vec%0d", i), vecs[i].ce, vecs[i].exp);
    end
    step(1);
    check("rd_data_idle", rd_data,       32'h0);
    check("rdack_pulse",  32'(rd_ack),   32'h0);

    // Held SAMPLE strobe: one push, one ack.
    @(negedge clk);
    bus_data = 32'h1234_0155;
    wr_ce    = CE_SAMP;
    acks     = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_ack) acks++;
    end
    wr_ce = '0;
    check("held_ce_acks", acks, 32'h1);
    bus_rd("status_one", CE_STAT, 32'h0000_0100);

    // Enable with DIV=1: data two cycles after ack, then underrun to midscale.
    bus_wr("en1", CE_CTRL, 32'h1);
    step(1);
    check("en1_dclk_a1", 32'(dclk), 32'h1);
    step(1);
    check("en1_data_a2", 32'(dac_data), 32'h155);
    check("en1_dclk_a2", 32'(dclk), 32'h0);
    step(1);
    check("en1_data_a3", 32'(dac_data), 32'h155);
    check("en1_dclk_a3", 32'(dclk), 32'h1);
    step(1);
    check("en1_data_a4", 32'(dac_data), 32'h200);
    check("en1_irq_off", 32'(irq), 32'h0);
    bus_wr("off1", CE_CTRL, 32'h2);
    bus_rd("status_udr", CE_STAT, 32'h0000_0005);
    bus_rd("status_udr_clr", CE_STAT, 32'h0000_0001);
    check("pwrdn_back", 32'(pwrdn), 32'h1);

    // DIV=3 pacing: samples every 4 cycles, clock 0,0,1,1.
    bus_wr("div3", CE_DIV, 32'h3);
    bus_wr("push1", CE_SAMP, 32'h001);
    bus_wr("push2", CE_SAMP, 32'h002);
    bus_wr("push3", CE_SAMP, 32'h003);
    bus_wr("en3", CE_CTRL, 32'h1);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) begin
        exp_d = 32'h200;
        exp_c = 32'h1;
      end else begin
        exp_d = ((k - 2) / 4 < 3) ? 32'((k - 2) / 4 + 1) : 32'h200;
        exp_c = (((k - 2) % 4) >= 2) ? 32'h1 : 32'h0;
      end
      check($sformatf("pace_data_k%0d", k), 32'(dac_data), exp_d);
      check($sformatf("pace_dclk_k%0d", k), 32'(dclk), exp_c);
    end
    bus_wr("off3", CE_CTRL, 32'h2);
    bus_rd("status_pace", CE_STAT, 32'h0000_0005);

    // Overflow with the scheduler off.
    for (int i = 0; i <= int'(DEPTH); i++) bus_wr($sformatf("fill%0d", i), CE_SAMP, 32'(i));
    bus_rd("status_ovf", CE_STAT, 32'h0000_100A);
    bus_rd("status_ovf_clr", CE_STAT, 32'h0000_1002);
    bus_wr("flush_full", CE_CTRL, 32'h6);
    bus_rd("status_flushed", CE_STAT, 32'h0000_0001);

    // HOLD keeps the last sample on underrun; FLUSH leaves the sticky flag.
    bus_wr("div1", CE_DIV, 32'h1);
    bus_wr("push_2aa", CE_SAMP, 32'h2AA);
    bus_wr("en_hold", CE_CTRL, 32'h19);
    step(2);
    check("hold_data_a2", 32'(dac_data), 32'h2AA);
    check("hold_irq_a2", 32'(irq), 32'h0);
    step(2);
    check("hold_data_a4", 32'(dac_data), 32'h2AA);
    check("hold_irq_a4", 32'(irq), 32'h1);
    step(2);
    check("hold_data_a6", 32'(dac_data), 32'h2AA);
    bus_wr("flush_run", CE_CTRL, 32'h1D);
    check("flush_dclk_f0", 32'(dclk), 32'h0);
    step(1);
    check("flush_dclk_f1", 32'(dclk), 32'h0);
    check("flush_irq_kept", 32'(irq), 32'h1);
    bus_rd("status_after_flush", CE_STAT, 32'h0000_0005);
    check("irq_cleared", 32'(irq), 32'h0);
    bus_rd("ctrl_flush_reads0", CE_CTRL, 32'h0000_0019);
    step(2);
    check("wait_dclk", 32'(dclk), 32'h0);

    // Asynchronous reset in the middle of a running period.
    bus_wr("off6", CE_CTRL, 32'h2);
    bus_wr("div7", CE_DIV, 32'h7);
    bus_wr("push_ab", CE_SAMP, 32'h0AB);
    bus_wr("push_155", CE_SAMP, 32'h155);
    bus_wr("en6", CE_CTRL, 32'h1);
    step(2);
    check("run_data_a2", 32'(dac_data), 32'h0AB);
    step(4);
    check("run_dclk_a6", 32'(dclk), 32'h1);
    #2 resetn = 1'b0;
    #1;
    check("arst_dac_data", 32'(dac_data), 32'h0);
    check("arst_dclk",     32'(dclk),     32'h0);
    check("arst_pwrdn",    32'(pwrdn),    32'h1);
    check("arst_irq",      32'(irq),      32'h0);
    check("arst_rd_data",  rd_data,       32'h0);
    step(2);
    resetn = 1'b1;
    bus_rd("post_rst_status", CE_STAT, 32'h0000_0001);
    bus_rd("post_rst_ctrl",   CE_CTRL, 32'h0000_0002);
    bus_rd("post_rst_div",    CE_DIV,  32'h0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
